// File: rtl/mannix_vec_pkg.sv
// Shared types for the 8-lane vector datapath.
// Lane index/count types, output register states, default element type.
package mannix_vec_pkg;

  localparam int LANES = 8;
  localparam int DEF_WIDTH = 16;

  typedef logic [2:0] lane_idx_t;
  typedef logic [3:0] lane_cnt_t;

  typedef logic signed [2*DEF_WIDTH-1:0] elem_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_t;

endpackage

// File: rtl/vec_packer_8.sv
// Packs a serial stream of signed 2*WIDTH-bit elements into zero-padded
// 8-lane vectors. Ports: in_valid/in_ready/in_data/in_last, out_valid/out_ready/out_vec/out_count/out_last.
module vec_packer_8
  import mannix_vec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [2*WIDTH-1:0] in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] out_vec [0:LANES-1],
  output lane_cnt_t                 out_count,
  output logic                      out_last
);

  logic signed [2*WIDTH-1:0] fill_vec [LANES];
  lane_idx_t lane;
  ostate_t   ostate;

  logic in_fire;
  logic out_fire;
  logic done;

  assign out_valid = (ostate == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign done      = in_fire && (in_last || lane == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      ostate    <= EMPTY;
      lane      <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        fill_vec[i] <= '0;
        out_vec[i]  <= '0;
      end
    end else begin
      if (done) begin
        // Lanes above the closing one are still zero in fill_vec.
        for (int i = 0; i < LANES; i++) begin
          out_vec[i]  <= (lane_idx_t'(i) == lane) ? in_data : fill_vec[i];
          fill_vec[i] <= '0;
        end
        out_count <= {1'b0, lane} + 4'd1;
        out_last  <= in_last;
        lane      <= '0;
        ostate    <= FULL;
      end else begin
        if (in_fire) begin
          fill_vec[lane] <= in_data;
          lane           <= lane + 3'd1;
        end
        if (out_fire) begin
          ostate <= EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_packer_8.sv
// Directed bench for vec_packer_8.
// Checks full/partial/single groups, back-pressure and reset mid-fill.
module tb_vec_packer_8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_vec [0:7];
  logic [3:0]         out_count;
  logic               out_last;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] ev [8];

  always #5 clk = ~clk;

  vec_packer_8 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_count (out_count),
    .out_last  (out_last)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag,
                         input logic [31:0] e [8],
                         input logic [3:0] c,
                         input logic l);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s.lane%0d", tag, i), out_vec[i], e[i]);
    chk({tag, ".count"}, 32'(out_count), 32'(c));
    chk({tag, ".last"}, 32'(out_last), 32'(l));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".count"}, 32'(out_count), 32'd0);
    chk({tag, ".last"}, 32'(out_last), 32'd0);
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s.lane%0d", tag, i), out_vec[i], 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'h0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;

    // two steady full groups 1..16
    for (int k = 1; k <= 7; k++) beat(32'(k), 1'b0);
    chk("g1.pre_valid", 32'(out_valid), 32'd0);
    beat(32'd8, 1'b0);
    ev = '{1, 2, 3, 4, 5, 6, 7, 8};
    chk_vec("g1", ev, 4'd8, 1'b0);
    beat(32'd9, 1'b0);
    chk("g2.drop", 32'(out_valid), 32'd0);
    for (int k = 10; k <= 15; k++) beat(32'(k), 1'b0);
    chk("g2.pre_valid", 32'(out_valid), 32'd0);
    beat(32'd16, 1'b0);
    ev = '{9, 10, 11, 12, 13, 14, 15, 16};
    chk_vec("g2", ev, 4'd8, 1'b0);
    tick();
    chk("idle.valid", 32'(out_valid), 32'd0);

    // partial group of 3
    beat(32'hFFFF_FFFB, 1'b0);
    beat(32'd7, 1'b0);
    beat(32'h7FFF_FFFF, 1'b1);
    ev = '{32'hFFFF_FFFB, 7, 32'h7FFF_FFFF, 0, 0, 0, 0, 0};
    chk_vec("part", ev, 4'd3, 1'b1);
    tick();

    // single-element group
    beat(32'h8000_0000, 1'b1);
    ev = '{32'h8000_0000, 0, 0, 0, 0, 0, 0, 0};
    chk_vec("single", ev, 4'd1, 1'b1);
    tick();

    // back-pressure: hold a full vector for 5 cycles
    for (int k = 101; k <= 107; k++) beat(32'(k), 1'b0);
    beat(32'd108, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("bp.in_ready", 32'(in_ready), 32'd0);
    ev = '{101, 102, 103, 104, 105, 106, 107, 108};
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_vec($sformatf("bp.hold%0d", c), ev, 4'd8, 1'b0);
      chk("bp.in_ready_h", 32'(in_ready), 32'd0);
    end
    // release together with a completing beat: back-to-back handoff
    out_ready = 1'b1;
    beat(32'h55, 1'b1);
    ev = '{32'h55, 0, 0, 0, 0, 0, 0, 0};
    chk_vec("bp.handoff", ev, 4'd1, 1'b1);
    tick();
    chk("bp.drain", 32'(out_valid), 32'd0);

    // reset mid-fill
    for (int k = 0; k < 4; k++) beat(32'h11 + 32'(k), 1'b0);
    rst = 1'b1;
    tick();
    chk_zero("rst_mid");
    rst = 1'b0;
    for (int k = 0; k < 7; k++) beat(32'h21 + 32'(k), 1'b0);
    chk("post.pre_valid", 32'(out_valid), 32'd0);
    beat(32'h28, 1'b0);
    ev = '{32'h21, 32'h22, 32'h23, 32'h24,
           32'h25, 32'h26, 32'h27, 32'h28};
    chk_vec("post", ev, 4'd8, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/vec_packer_8.md
# vec_packer_8

Streaming packer that gathers a serial stream of signed `2*WIDTH`-bit products into an 8-lane vector for the 8-input signed reduction stage. Sits between the multiplier array output and the adder tree in the standalone datapath. It turns one element per cycle into one zero-padded vector per group, with valid/ready handshakes on both sides. Unfilled lanes are zero, so a downstream sum over a partial group is correct.

## Interface

- `WIDTH`, 16, half the element width; each element and lane is `2*WIDTH` bits signed.
- `LANES`, 8, vector lanes; fixed at 8 for this block.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `in_valid` input 1 — `in_data` is valid.
- `in_ready` output 1 — packer accepts `in_data` this cycle.
- `in_data` input `2*WIDTH` signed — one element.
- `in_last` input 1 — the current element closes the group, even if the group is partial.
- `out_valid` output 1 — `out_vec`, `out_count` and `out_last` are valid.
- `out_ready` input 1 — the consumer takes the vector this cycle.
- `out_vec` output `[0:LANES-1]` × `2*WIDTH` signed — packed vector, lane 0 = first element.
- `out_count` output 4 — number of filled lanes, 1..8.
- `out_last` output 1 — the vector was closed by `in_last`, not by filling all lanes.

## Operation

- An input beat is accepted when `in_valid && in_ready`. An output beat is taken when `out_valid && out_ready`.
- Fill stage: `fill_vec[LANES]`, `lane` counter 0..7, all zero after reset.
- Each accepted element is written to `fill_vec[lane]`.
  - If `lane==7` or `in_last`, the beat completes the vector.
  - Otherwise `lane` increments.
- On a completing beat:
  - The output register loads `fill_vec` with the new element inserted.
  - `out_count` is set to `lane+1` and `out_last` to `in_last`.
  - `fill_vec` clears to zero and `lane` returns to 0.
- Lanes at index `>= out_count` are exactly zero.
- Output register states:
  - EMPTY (`out_valid=0`): a completing beat moves it to FULL.
  - FULL: an output beat with no completing beat moves it to EMPTY. An output beat together with a completing beat reloads the register and stays FULL.
- `in_ready = !out_valid || out_ready`. This conservatively stalls all input while a vector is held unconsumed.
- No arithmetic is performed; data passes bit-exact. The sign is meaningful only for downstream use.
- Reset behaviour:
  - Outputs: `out_valid=0`, `out_vec` all zero, `out_count=0`, `out_last=0`, `in_ready=1`.
  - Internal state: `lane=0`, `fill_vec` all zero.
  - Reset mid-fill or with a held vector discards everything; no partial vector is emitted.

## Timing

- Latency: a completing beat at cycle N gives `out_valid=1` at N+1.
- Throughput: one element per cycle sustained when `out_ready` is held at 1. A full group of 8 produces one vector every 8 cycles.
- `in_ready` is combinational from `out_valid` (registered) and `out_ready`. There is no other combinational input-to-output path.
- `out_vec`, `out_count` and `out_last` stay stable while `out_valid && !out_ready`.
- `in_last` is sampled only on accepted beats. `in_data` is ignored when there is no handshake.

## Structure

- Shared package `mannix_vec_pkg`:
  - `localparam LANES = 8`
  - `typedef logic [2:0] lane_idx_t`
  - `typedef logic [3:0] lane_cnt_t`
  - the parameterised element type `logic signed [2*WIDTH-1:0]` expressed through `WIDTH`.
- Single module, no sub-module. The fill stage and the output register are both simple enough to stay inline.

## Test plan

- Steady full groups: 16 beats, values 1..16, `in_last` low, `out_ready=1`.
  - Two vectors: {1..8} then {9..16}.
  - `out_count=8`, `out_last=0`.
  - `out_valid` asserted the cycle after the 8th and 16th beats.
- Partial group: 3 beats of −5, 7, 0x7FFFFFFF (`WIDTH=16`), with `in_last` on the 3rd.
  - `out_vec` = {−5, 7, 0x7FFFFFFF, 0,0,0,0,0}.
  - `out_count=3`, `out_last=1`.
- Single-element group: `in_last` on the first beat with value 0x80000000.
  - `out_count=1`, lane 0 = 0x80000000, lanes 1..7 = 0.
- Back-pressure: hold `out_ready=0` after the first vector completes.
  - `in_ready=0`; the vector stays stable for 5 cycles.
  - Raising `out_ready` together with the next complete group gives a back-to-back handoff, with `out_valid` never dropping.
- Reset mid-fill: 4 beats accepted, then `rst` for 1 cycle, then a full group of 8.
  - The first vector out holds only the post-reset elements.
  - All outputs are zero during reset; `in_ready=1` after reset.
